// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard control bundle between the stage modules and pipe_hazard_ctrl.
// master = stage side raising requests, slave = the controller.
interface pipe_hazard_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int STAGES = 5
);
    logic              hold_i;
    logic [STAGES-1:0] stall_req_i;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              hold_ena_o;
    logic [STAGES-1:0] stall_o;
    logic [STAGES-1:0] flush_o;
    logic              jump_ena_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              jump_pending_o;
    logic              hold_timeout_o;
    logic [31:0]       stall_cycles_o;

    modport master (
        output hold_i, stall_req_i, jump_i, jump_addr_i,
        input  hold_ena_o, stall_o, flush_o, jump_ena_o, jump_addr_o,
        input  jump_pending_o, hold_timeout_o, stall_cycles_o
    );

    modport slave (
        input  hold_i, stall_req_i, jump_i, jump_addr_i,
        output hold_ena_o, stall_o, flush_o, jump_ena_o, jump_addr_o,
        output jump_pending_o, hold_timeout_o, stall_cycles_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: merges bus hold, stall requests and redirects into
// per-stage stall/flush vectors, with deferred redirect and hold watchdog.
module pipe_hazard_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int STAGES       = 5,
    parameter int JUMP_STAGE   = 2,
    parameter int HOLD_TIMEOUT = 255
) (
    input logic               clk_100MHz,
    input logic               srst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int CW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_MAX = CW'(HOLD_TIMEOUT);
    localparam logic [CW-1:0] WD_LAST =
        CW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

    function automatic logic [STAGES-1:0] upto(input int n);
        logic [STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < STAGES; i++)
            if (i <= n) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [STAGES-1:0] JMP_ZONE  = upto(JUMP_STAGE);
    localparam logic [STAGES-1:0] JMP_FLUSH = JMP_ZONE & ~upto(0);

    typedef enum logic {IDLE, PEND} pend_e;

    pend_e             state, state_n;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [CW-1:0]     wd_cnt;
    logic              wd_flag;
    logic [31:0]       stall_cnt;

    logic              pending;
    logic              blocked;
    logic              src_valid;
    logic [ADDR_W-1:0] src_addr;
    logic              issue;
    logic [STAGES-1:0] req_mask;
    logic [STAGES-1:0] req_flush;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;

    assign pending   = (state == PEND);
    assign blocked   = bus.hold_i | (|bus.stall_req_i[STAGES-1:JUMP_STAGE]);
    assign src_valid = pending | bus.jump_i;
    assign src_addr  = pending ? pend_addr : bus.jump_addr_i;
    assign issue     = src_valid & ~blocked;

    always_ff @(posedge clk_100MHz) begin
        if (srst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.jump_i && blocked) state_n = PEND;
            PEND: if (!blocked) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Everything at or below the oldest requester stalls; the stage
    // just above it takes a bubble.
    always_comb begin
        logic acc;
        acc       = 1'b0;
        req_mask  = '0;
        req_flush = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            acc         = acc | bus.stall_req_i[j];
            req_mask[j] = acc;
        end
        for (int j = 1; j < STAGES; j++)
            req_flush[j] = req_mask[j-1] & ~req_mask[j];
    end

    always_comb begin
        stall          = '0;
        flush          = '0;
        bus.hold_ena_o = 1'b0;
        bus.jump_ena_o = 1'b0;
        if (srst) begin
            flush = '1;
        end else if (bus.hold_i) begin
            bus.hold_ena_o = 1'b1;
            stall          = '1;
        end else if (issue) begin
            bus.jump_ena_o = 1'b1;
            stall          = req_mask & ~JMP_ZONE;
            flush          = req_flush | JMP_FLUSH;
        end else begin
            stall = req_mask;
            flush = req_flush;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (srst) begin
            pend_addr <= '0;
            last_addr <= '0;
        end else begin
            if (state == IDLE && bus.jump_i && blocked)
                pend_addr <= bus.jump_addr_i;
            if (src_valid)
                last_addr <= src_addr;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (srst) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else begin
            if (!bus.hold_i)          wd_cnt <= '0;
            else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
            if (HOLD_TIMEOUT != 0 && bus.hold_i && wd_cnt >= WD_LAST)
                wd_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (srst)
            stall_cnt <= '0;
        else if (stall[0] && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign bus.stall_o        = stall;
    assign bus.flush_o        = flush;
    assign bus.jump_addr_o    = src_valid ? src_addr : last_addr;
    assign bus.jump_pending_o = pending;
    assign bus.hold_timeout_o = wd_flag;
    assign bus.stall_cycles_o = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed plan cases plus random traffic,
// all checked against a rule-level model of the controller.
module tb_pipe_hazard_ctrl;
    localparam int AW = 32;
    localparam int ST = 5;
    localparam int JS = 2;
    localparam int HT = 4;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.ADDR_W(AW), .STAGES(ST)) bus ();

    pipe_hazard_ctrl #(
        .ADDR_W(AW), .STAGES(ST), .JUMP_STAGE(JS), .HOLD_TIMEOUT(HT)
    ) dut (
        .clk_100MHz(clk),
        .srst(srst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    bit          m_pend;
    logic [31:0] m_paddr;
    logic [31:0] m_last;
    logic [31:0] m_cycles;
    int          m_wd;
    bit          m_to;

    bit          e_blocked, e_src, e_issue, e_jena, e_hena;
    logic [31:0] e_saddr, e_addr;
    logic [ST-1:0] e_stall, e_flush;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_comb();
        int k;
        int s, f;
        k = -1;
        for (int i = 0; i < ST; i++)
            if (bus.stall_req_i[i]) k = i;
        e_blocked = bus.hold_i || (k >= JS);
        e_src     = m_pend || bus.jump_i;
        e_saddr   = m_pend ? m_paddr : bus.jump_addr_i;
        e_issue   = e_src && !e_blocked && !srst;
        e_addr    = e_src ? e_saddr : m_last;
        e_jena = 0; e_hena = 0;
        s = 0; f = 0;
        if (srst) begin
            f = (1 << ST) - 1;
        end else if (bus.hold_i) begin
            e_hena = 1;
            s = (1 << ST) - 1;
        end else begin
            if (k >= 0) s = (1 << (k + 1)) - 1;
            if (k >= 0 && k + 1 < ST) f = 1 << (k + 1);
            if (e_issue) begin
                e_jena = 1;
                s = s & ~((1 << (JS + 1)) - 1);
                f = f | ((1 << (JS + 1)) - 2);
            end
        end
        e_stall = ST'(s);
        e_flush = ST'(f);
    endtask

    task automatic model_seq();
        if (srst) begin
            m_pend = 0; m_paddr = 0; m_last = 0;
            m_cycles = 0; m_wd = 0; m_to = 0;
        end else begin
            if (e_src) m_last = e_saddr;
            if (m_pend && e_issue) m_pend = 0;
            else if (!m_pend && bus.jump_i && e_blocked) begin
                m_pend  = 1;
                m_paddr = bus.jump_addr_i;
            end
            if (bus.hold_i) begin
                m_wd = (m_wd + 1 > HT) ? HT : m_wd + 1;
                if (m_wd == HT) m_to = 1;
            end else begin
                m_wd = 0;
            end
            if (e_stall[0] && m_cycles != 32'hFFFF_FFFF)
                m_cycles = m_cycles + 1;
        end
    endtask

    task automatic compare_all();
        chk("stall_o", 64'(bus.stall_o), 64'(e_stall));
        chk("flush_o", 64'(bus.flush_o), 64'(e_flush));
        chk("hold_ena_o", 64'(bus.hold_ena_o), 64'(e_hena));
        chk("jump_ena_o", 64'(bus.jump_ena_o), 64'(e_jena));
        if (!srst)
            chk("jump_addr_o", 64'(bus.jump_addr_o), 64'(e_addr));
        chk("jump_pending_o", 64'(bus.jump_pending_o), 64'(m_pend));
        chk("hold_timeout_o", 64'(bus.hold_timeout_o), 64'(m_to));
        chk("stall_cycles_o", 64'(bus.stall_cycles_o), 64'(m_cycles));
    endtask

    task automatic drive(input bit r, input bit h, input logic [ST-1:0] q,
                         input bit j, input logic [31:0] a);
        srst            = r;
        bus.hold_i      = h;
        bus.stall_req_i = q;
        bus.jump_i      = j;
        bus.jump_addr_i = a;
    endtask

    task automatic cycle(input bit r, input bit h, input logic [ST-1:0] q,
                         input bit j, input logic [31:0] a);
        drive(r, h, q, j, a);
        #4;
        model_comb();
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, '0, 0, 32'h0);
    endtask

    initial begin
        drive(1, 0, '0, 0, 32'h0);
        @(posedge clk);
        #1;
        model_comb();
        @(posedge clk);
        model_seq();
        #1;

        cycle(1, 0, '0, 0, 32'h0);
        chk("rst_flush", 64'(bus.flush_o), 64'h1F);
        chk("rst_pending", 64'(bus.jump_pending_o), 64'h0);
        tick();

        // stall bubble
        cycle(0, 0, 5'b00100, 0, 32'h0);
        chk("bub_stall", 64'(bus.stall_o), 64'h07);
        chk("bub_flush", 64'(bus.flush_o), 64'h08);
        chk("bub_jena", 64'(bus.jump_ena_o), 64'h0);
        chk("bub_cnt0", 64'(bus.stall_cycles_o), 64'h0);
        tick();
        idle();
        chk("bub_cnt1", 64'(bus.stall_cycles_o), 64'h1);
        tick();

        // direct jump
        cycle(0, 0, '0, 1, 32'h80);
        chk("dj_jena", 64'(bus.jump_ena_o), 64'h1);
        chk("dj_addr", 64'(bus.jump_addr_o), 64'h80);
        chk("dj_flush", 64'(bus.flush_o), 64'h06);
        chk("dj_stall", 64'(bus.stall_o), 64'h0);
        tick();
        idle();
        chk("dj_pend", 64'(bus.jump_pending_o), 64'h0);
        tick();

        // deferred jump
        cycle(0, 0, 5'b01000, 1, 32'h100);
        chk("def_jena0", 64'(bus.jump_ena_o), 64'h0);
        tick();
        for (int i = 1; i <= 2; i++) begin
            cycle(0, 0, 5'b01000, 1, 32'h200);
            chk("def_pend", 64'(bus.jump_pending_o), 64'h1);
            chk("def_jena", 64'(bus.jump_ena_o), 64'h0);
            tick();
        end
        cycle(0, 0, '0, 1, 32'h200);
        chk("def_rel_pend", 64'(bus.jump_pending_o), 64'h1);
        chk("def_rel_jena", 64'(bus.jump_ena_o), 64'h1);
        chk("def_rel_addr", 64'(bus.jump_addr_o), 64'h100);
        tick();
        idle();
        chk("def_after_pend", 64'(bus.jump_pending_o), 64'h0);
        chk("def_after_jena", 64'(bus.jump_ena_o), 64'h0);
        tick();

        // hold priority
        cycle(0, 1, 5'b00001, 1, 32'h300);
        chk("hp_stall", 64'(bus.stall_o), 64'h1F);
        chk("hp_flush", 64'(bus.flush_o), 64'h0);
        chk("hp_hena", 64'(bus.hold_ena_o), 64'h1);
        chk("hp_jena", 64'(bus.jump_ena_o), 64'h0);
        tick();
        idle();
        chk("hp_pend", 64'(bus.jump_pending_o), 64'h1);
        chk("hp_rel_jena", 64'(bus.jump_ena_o), 64'h1);
        chk("hp_rel_addr", 64'(bus.jump_addr_o), 64'h300);
        tick();
        idle();
        chk("hp_once", 64'(bus.jump_ena_o), 64'h0);
        tick();

        // watchdog
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, '0, 0, 32'h0);
            tick();
        end
        idle();
        chk("wd_burst1", 64'(bus.hold_timeout_o), 64'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, '0, 0, 32'h0);
            if (i == 3) chk("wd_pre", 64'(bus.hold_timeout_o), 64'h0);
            tick();
        end
        idle();
        chk("wd_set", 64'(bus.hold_timeout_o), 64'h1);
        tick();
        idle();
        chk("wd_sticky", 64'(bus.hold_timeout_o), 64'h1);
        tick();

        // reset mid-operation
        cycle(0, 0, 5'b01000, 1, 32'h400);
        tick();
        cycle(1, 0, '0, 0, 32'h0);
        chk("mr_flush", 64'(bus.flush_o), 64'h1F);
        chk("mr_stall", 64'(bus.stall_o), 64'h0);
        chk("mr_pend_in", 64'(bus.jump_pending_o), 64'h1);
        tick();
        idle();
        chk("mr_pend", 64'(bus.jump_pending_o), 64'h0);
        chk("mr_cnt", 64'(bus.stall_cycles_o), 64'h0);
        chk("mr_to", 64'(bus.hold_timeout_o), 64'h0);
        chk("mr_jena", 64'(bus.jump_ena_o), 64'h0);
        tick();
        idle();
        chk("mr_jena2", 64'(bus.jump_ena_o), 64'h0);
        tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            bit r, h, j;
            logic [ST-1:0] q;
            r = ($urandom_range(0, 59) == 0);
            h = ($urandom_range(0, 5) == 0);
            q = ($urandom_range(0, 2) == 0) ? ST'($urandom) : '0;
            j = ($urandom_range(0, 2) == 0);
            cycle(r, h, q, j, $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
